// File: rtl/cycle_sequencer_if.sv
// Signal bundle between the cycle sequencer and its driver: control inputs
// plus the timing and instruction-decode outputs the microcode blocks consume.
interface cycle_sequencer_if #(
  parameter int COUNT_WIDTH = 8
);
  logic                   i_Stall;
  logic [7:0]             i_Data_Bus;
  logic                   i_Reset_Cycle;
  logic [3:0]             o_Cycle_Step;
  logic [COUNT_WIDTH-1:0] o_Cycle_Count;
  logic                   o_Fetch;
  logic [7:0]             o_Opcode;
  logic                   o_Rst_Active;
  logic [2:0]             o_Rst_Vector;
  logic                   o_Overrun;

  modport master (
    output i_Stall, i_Data_Bus, i_Reset_Cycle,
    input  o_Cycle_Step, o_Cycle_Count, o_Fetch, o_Opcode,
           o_Rst_Active, o_Rst_Vector, o_Overrun
  );

  modport slave (
    input  i_Stall, i_Data_Bus, i_Reset_Cycle,
    output o_Cycle_Step, o_Cycle_Count, o_Fetch, o_Opcode,
           o_Rst_Active, o_Rst_Vector, o_Overrun
  );
endinterface

// File: rtl/cycle_sequencer.sv
// T-state / M-cycle timing generator and opcode latch feeding the microcode
// blocks; returns to opcode fetch on a reset-cycle request or count overrun.
module cycle_sequencer #(
  parameter int         COUNT_WIDTH  = 8,
  parameter logic [7:0] RESET_OPCODE = 8'h00
) (
  input  logic              i_Clk,
  input  logic              i_Reset,
  cycle_sequencer_if.slave  bus
);

  typedef enum logic {PH_FETCH, PH_EXEC} phase_t;

  localparam logic [COUNT_WIDTH-1:0] COUNT_FIRST = {{(COUNT_WIDTH-1){1'b0}}, 1'b1};

  phase_t                 phase_q, phase_d;
  logic [3:0]             step_q, step_d;
  logic [COUNT_WIDTH-1:0] count_q, count_d;
  logic [7:0]             opcode_q, opcode_d;
  logic                   overrun_q, overrun_d;

  always_ff @(posedge i_Clk) begin
    if (i_Reset) begin
      phase_q   <= PH_FETCH;
      step_q    <= 4'b0001;
      count_q   <= '0;
      opcode_q  <= RESET_OPCODE;
      overrun_q <= 1'b0;
    end else begin
      phase_q   <= phase_d;
      step_q    <= step_d;
      count_q   <= count_d;
      opcode_q  <= opcode_d;
      overrun_q <= overrun_d;
    end
  end

  // Every M-cycle boundary decision happens on T4; other steps only rotate.
  always_comb begin
    phase_d   = phase_q;
    step_d    = step_q;
    count_d   = count_q;
    opcode_d  = opcode_q;
    overrun_d = overrun_q;
    if (!bus.i_Stall) begin
      step_d = {step_q[2:0], step_q[3]};
      if (step_q[3]) begin
        if (phase_q == PH_FETCH) begin
          opcode_d = bus.i_Data_Bus;
          if (!bus.i_Reset_Cycle) begin
            phase_d = PH_EXEC;
            count_d = COUNT_FIRST;
          end
        end else if (bus.i_Reset_Cycle) begin
          phase_d = PH_FETCH;
          count_d = '0;
        end else if (count_q[COUNT_WIDTH-1]) begin
          phase_d   = PH_FETCH;
          count_d   = '0;
          overrun_d = 1'b1;
        end else begin
          count_d = {count_q[COUNT_WIDTH-2:0], 1'b0};
        end
      end
    end
  end

  assign bus.o_Cycle_Step  = step_q;
  assign bus.o_Cycle_Count = count_q;
  assign bus.o_Fetch       = (phase_q == PH_FETCH);
  assign bus.o_Opcode      = opcode_q;
  assign bus.o_Overrun     = overrun_q;
  assign bus.o_Rst_Vector  = opcode_q[5:3];
  assign bus.o_Rst_Active  = (phase_q != PH_FETCH) && (opcode_q[7:6] == 2'b11)
                             && (opcode_q[2:0] == 3'b111);

endmodule

// File: tb/tb_cycle_sequencer.sv
// Directed-vector bench for cycle_sequencer: fetch looping, RST decode,
// stall freezing, count overrun and mid-instruction reset.
module tb_cycle_sequencer;

  logic clk = 1'b0;
  logic reset;
  int   checkCount = 0;
  int   passCount  = 0;

  cycle_sequencer_if #(.COUNT_WIDTH(8)) bus ();

  cycle_sequencer #(.COUNT_WIDTH(8), .RESET_OPCODE(8'h00)) dut (
    .i_Clk   (clk),
    .i_Reset (reset),
    .bus     (bus.slave)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checkCount++;
    if (observed === expected) passCount++;
    else $display("[TB] FAIL %s: got %0h expected %0h", tag, observed, expected);
  endtask

  task automatic applyStimulus(input logic stall, input logic [7:0] data,
                               input logic resetCycle);
    bus.i_Stall       = stall;
    bus.i_Data_Bus    = data;
    bus.i_Reset_Cycle = resetCycle;
  endtask

  task automatic tick;
    @(negedge clk);
  endtask

  task automatic checkPhase(input string tag, input logic [3:0] expStep,
                            input logic [7:0] expCount, input logic expFetch);
    checkOutput({tag, ".step"},  32'(bus.o_Cycle_Step),  32'(expStep));
    checkOutput({tag, ".count"}, 32'(bus.o_Cycle_Count), 32'(expCount));
    checkOutput({tag, ".fetch"}, 32'(bus.o_Fetch),       32'(expFetch));
  endtask

  // Walk one full M-cycle from T1, optionally raising the reset-cycle request on T4.
  task automatic runMcycle(input string tag, input logic [7:0] expCount,
                           input logic expFetch, input logic rcAtT4);
    for (int t = 0; t < 4; t++) begin
      if (t == 3) bus.i_Reset_Cycle = rcAtT4;
      checkPhase($sformatf("%s.T%0d", tag, t + 1), 4'(1 << t), expCount, expFetch);
      tick();
    end
    bus.i_Reset_Cycle = 1'b0;
  endtask

  task automatic fetchOpcode(input logic [7:0] op);
    applyStimulus(1'b0, op, 1'b0);
    runMcycle($sformatf("fetch%02h", op), 8'h00, 1'b1, 1'b0);
  endtask

  initial begin
    reset = 1'b1;
    applyStimulus(1'b0, 8'h00, 1'b0);
    tick();
    tick();
    reset = 1'b0;

    checkPhase("reset", 4'b0001, 8'h00, 1'b1);
    checkOutput("reset.opcode",  32'(bus.o_Opcode),  32'h00);
    checkOutput("reset.overrun", 32'(bus.o_Overrun), 32'h0);

    // Zero-execution-cycle instructions keep the sequencer parked in fetch.
    applyStimulus(1'b0, 8'h00, 1'b1);
    for (int i = 0; i < 8; i++) begin
      checkPhase($sformatf("loop%0d", i), 4'(1 << (i % 4)), 8'h00, 1'b1);
      checkOutput("loop.opcode", 32'(bus.o_Opcode), 32'h00);
      tick();
    end

    fetchOpcode(8'hFF);
    checkOutput("ff.opcode", 32'(bus.o_Opcode),     32'hFF);
    checkOutput("ff.active", 32'(bus.o_Rst_Active), 32'h1);
    checkOutput("ff.vector", 32'(bus.o_Rst_Vector), 32'h7);
    runMcycle("ff.c1", 8'h01, 1'b0, 1'b0);
    runMcycle("ff.c2", 8'h02, 1'b0, 1'b0);
    runMcycle("ff.c4", 8'h04, 1'b0, 1'b0);
    runMcycle("ff.c8", 8'h08, 1'b0, 1'b1);
    checkPhase("ff.end", 4'b0001, 8'h00, 1'b1);
    checkOutput("ff.end.active", 32'(bus.o_Rst_Active), 32'h0);

    fetchOpcode(8'hCF);
    checkOutput("cf.active", 32'(bus.o_Rst_Active), 32'h1);
    checkOutput("cf.vector", 32'(bus.o_Rst_Vector), 32'h1);
    runMcycle("cf.c1", 8'h01, 1'b0, 1'b1);

    fetchOpcode(8'hC7);
    checkOutput("c7.active", 32'(bus.o_Rst_Active), 32'h1);
    checkOutput("c7.vector", 32'(bus.o_Rst_Vector), 32'h0);
    runMcycle("c7.c1", 8'h01, 1'b0, 1'b1);

    fetchOpcode(8'hC3);
    checkOutput("c3.active", 32'(bus.o_Rst_Active), 32'h0);
    checkOutput("c3.vector", 32'(bus.o_Rst_Vector), 32'h0);
    runMcycle("c3.c1", 8'h01, 1'b0, 1'b1);

    // Stall mid M-cycle, then a stalled T4 that must ignore the reset-cycle request.
    fetchOpcode(8'hFF);
    runMcycle("st.c1", 8'h01, 1'b0, 1'b0);
    checkPhase("st.t1", 4'b0001, 8'h02, 1'b0);
    tick();
    checkPhase("st.t2", 4'b0010, 8'h02, 1'b0);
    tick();
    applyStimulus(1'b1, 8'h00, 1'b0);
    for (int i = 0; i < 3; i++) begin
      checkPhase($sformatf("st.hold%0d", i), 4'b0100, 8'h02, 1'b0);
      tick();
    end
    applyStimulus(1'b0, 8'h00, 1'b0);
    checkPhase("st.resume", 4'b0100, 8'h02, 1'b0);
    tick();
    checkPhase("st.t4", 4'b1000, 8'h02, 1'b0);
    tick();
    for (int t = 0; t < 3; t++) begin
      checkPhase($sformatf("st.c4.T%0d", t + 1), 4'(1 << t), 8'h04, 1'b0);
      tick();
    end
    applyStimulus(1'b1, 8'h00, 1'b1);
    tick();
    checkPhase("st.rcStalled", 4'b1000, 8'h04, 1'b0);
    applyStimulus(1'b0, 8'h00, 1'b0);
    tick();

    // Never end the instruction: count runs off the top and flags overrun.
    runMcycle("ov.c8",  8'h08, 1'b0, 1'b0);
    runMcycle("ov.c10", 8'h10, 1'b0, 1'b0);
    runMcycle("ov.c20", 8'h20, 1'b0, 1'b0);
    runMcycle("ov.c40", 8'h40, 1'b0, 1'b0);
    checkOutput("ov.before", 32'(bus.o_Overrun), 32'h0);
    runMcycle("ov.c80", 8'h80, 1'b0, 1'b0);
    checkPhase("ov.end", 4'b0001, 8'h00, 1'b1);
    checkOutput("ov.flag", 32'(bus.o_Overrun), 32'h1);

    fetchOpcode(8'hFF);
    checkOutput("ov.sticky1", 32'(bus.o_Overrun), 32'h1);
    runMcycle("rs.c1", 8'h01, 1'b0, 1'b0);
    runMcycle("rs.c2", 8'h02, 1'b0, 1'b0);
    tick();
    checkPhase("rs.pre", 4'b0010, 8'h04, 1'b0);
    checkOutput("ov.sticky2", 32'(bus.o_Overrun), 32'h1);

    // Reset overrides a simultaneous stall mid-instruction.
    applyStimulus(1'b1, 8'h00, 1'b0);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    applyStimulus(1'b0, 8'h00, 1'b0);
    checkPhase("rs.post", 4'b0001, 8'h00, 1'b1);
    checkOutput("rs.opcode",  32'(bus.o_Opcode),  32'h00);
    checkOutput("rs.overrun", 32'(bus.o_Overrun), 32'h0);

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
